// File: rtl/vc_mux3_domain_arbiter.sv
// Round-robin, packet-locking arbiter for three val/rdy requesters that share one mux datapath.
// Optional H->L scrub cycle enabled by defining VC_ARB_DOMAIN_SCRUB_EN.
module vc_mux3_domain_arbiter (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] in_val,
  input  logic [2:0] in_last,
  input  logic [2:0] in_domain,
  output logic [2:0] in_rdy,
  output logic       out_val,
  input  logic       out_rdy,
  output logic [1:0] sel,
  output logic [2:0] grant,
  output logic       out_domain
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StBusy  = 2'd1;
`ifdef VC_ARB_DOMAIN_SCRUB_EN
  localparam logic [1:0] StScrub = 2'd2;
`endif

  logic [1:0] state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic [2:0] grant_q, grant_d;
  logic [1:0] sel_q, sel_d;
  logic       out_domain_q, out_domain_d;
  logic       last_dom_q, last_dom_d;

  logic [1:0] cand0, cand1, cand2, winner;
  logic       any_req;
  logic       busy;
  logic       fire;

  function automatic logic [1:0] inc_mod3(input logic [1:0] v);
    return (v >= 2'd2) ? 2'd0 : v + 2'd1;
  endfunction

  // Search order starts at the pointer so the last-served requester goes to the back.
  always_comb begin
    cand0   = ptr_q;
    cand1   = inc_mod3(cand0);
    cand2   = inc_mod3(cand1);
    any_req = |in_val;
    if (in_val[cand0]) begin
      winner = cand0;
    end else if (in_val[cand1]) begin
      winner = cand1;
    end else begin
      winner = cand2;
    end
  end

  // Outputs are gated by reset so an in-flight beat cannot fire during the reset cycle.
  always_comb begin
    busy    = (state_q == StBusy) && !reset;
    out_val = busy && (|(in_val & grant_q));
    in_rdy  = busy ? (grant_q & {3{out_rdy}}) : 3'b000;
    fire    = out_val && out_rdy;
  end

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    grant_d      = grant_q;
    sel_d        = sel_q;
    out_domain_d = out_domain_q;
    last_dom_d   = last_dom_q;
    case (state_q)
      StIdle: begin
        if (any_req) begin
          grant_d      = 3'b001 << winner;
          sel_d        = winner;
          out_domain_d = in_domain[winner];
          last_dom_d   = in_domain[winner];
          state_d      = StBusy;
`ifdef VC_ARB_DOMAIN_SCRUB_EN
          // Moving from H to L inserts a dead cycle so the sink can flush H residue.
          if (!in_domain[winner] && last_dom_q) begin
            state_d = StScrub;
          end
`endif
        end
      end
`ifdef VC_ARB_DOMAIN_SCRUB_EN
      StScrub: begin
        state_d = StBusy;
      end
`endif
      StBusy: begin
        if (fire && in_last[sel_q]) begin
          ptr_d   = inc_mod3(sel_q);
          grant_d = 3'b000;
          state_d = StIdle;
        end
      end
      default: begin
        grant_d = 3'b000;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      ptr_q        <= 2'd0;
      grant_q      <= 3'b000;
      sel_q        <= 2'd0;
      out_domain_q <= 1'b0;
      last_dom_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      grant_q      <= grant_d;
      sel_q        <= sel_d;
      out_domain_q <= out_domain_d;
      last_dom_q   <= last_dom_d;
    end
  end

  assign grant      = grant_q;
  assign sel        = sel_q;
  assign out_domain = out_domain_q;

`ifndef SYNTHESIS
  a_rdy_onehot0 : assert property (@(posedge clk) disable iff (reset) $onehot0(in_rdy));
  a_val_granted : assert property (@(posedge clk) disable iff (reset)
                                   out_val |-> (grant != 3'b000));
`endif

endmodule

// File: tb/tb_vc_mux3_domain_arbiter.sv
// Directed bench for vc_mux3_domain_arbiter: reset, round-robin order, packet lock,
// domain latching, optional scrub cycle and reset mid-packet.
module tb_vc_mux3_domain_arbiter;

  logic       clk;
  logic       reset;
  logic [2:0] in_val;
  logic [2:0] in_last;
  logic [2:0] in_domain;
  logic [2:0] in_rdy;
  logic       out_val;
  logic       out_rdy;
  logic [1:0] sel;
  logic [2:0] grant;
  logic       out_domain;

  int checks = 0;
  int errors = 0;

  vc_mux3_domain_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .in_val     (in_val),
    .in_last    (in_last),
    .in_domain  (in_domain),
    .in_rdy     (in_rdy),
    .out_val    (out_val),
    .out_rdy    (out_rdy),
    .sel        (sel),
    .grant      (grant),
    .out_domain (out_domain)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int gs[4] = '{0, 1, 2, 0};

  initial begin
    // 1: reset held with all requesters active
    reset = 1'b1; in_val = 3'b111; in_last = 3'b000; in_domain = 3'b000; out_rdy = 1'b1;
    #1;
    chk("rst_pre_outval", {3'b0, out_val}, 4'h0);
    chk("rst_pre_inrdy", {1'b0, in_rdy}, 4'h0);
    repeat (2) begin
      step();
      chk("rst_grant", {1'b0, grant}, 4'h0);
      chk("rst_outval", {3'b0, out_val}, 4'h0);
      chk("rst_inrdy", {1'b0, in_rdy}, 4'h0);
      chk("rst_sel", {2'b0, sel}, 4'h0);
      chk("rst_outdom", {3'b0, out_domain}, 4'h0);
    end

    // 2: round-robin with single-beat packets
    reset = 1'b0; in_last = 3'b111;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk("rr_bubble_grant", {1'b0, grant}, 4'h0);
      chk("rr_bubble_outval", {3'b0, out_val}, 4'h0);
      step();
      chk("rr_grant", {1'b0, grant}, 4'(3'b001 << gs[k]));
      chk("rr_sel", {2'b0, sel}, 4'(gs[k]));
      chk("rr_outval", {3'b0, out_val}, 4'h1);
      chk("rr_inrdy", {1'b0, in_rdy}, 4'(3'b001 << gs[k]));
      step();
    end
    in_val = 3'b000;

    // 3: packet lock on req0 with req1 pending and a stalled sink
    reset = 1'b1;
    step();
    reset = 1'b0; in_val = 3'b011; in_last = 3'b000; out_rdy = 1'b1;
    #1;
    chk("lock_idle_grant", {1'b0, grant}, 4'h0);
    step();
    chk("lock_b1_grant", {1'b0, grant}, 4'h1);
    chk("lock_b1_inrdy", {1'b0, in_rdy}, 4'h1);
    step();
    out_rdy = 1'b0;
    #1;
    chk("lock_stall_inrdy", {1'b0, in_rdy}, 4'h0);
    chk("lock_stall_outval", {3'b0, out_val}, 4'h1);
    step();
    out_rdy = 1'b1;
    #1;
    chk("lock_b2_grant", {1'b0, grant}, 4'h1);
    step();
    in_last = 3'b001;
    #1;
    chk("lock_b3_grant", {1'b0, grant}, 4'h1);
    chk("lock_b3_inrdy", {1'b0, in_rdy}, 4'h1);
    step();
    chk("lock_bubble_grant", {1'b0, grant}, 4'h0);
    chk("lock_bubble_outval", {3'b0, out_val}, 4'h0);
    step();
    chk("lock_next_grant", {1'b0, grant}, 4'h2);
    in_last = 3'b010;
    step();
    in_val = 3'b000;

    // 4: domain latched at grant, ignored mid-packet
    in_val = 3'b100; in_domain = 3'b100; in_last = 3'b000;
    step();
    chk("dom_grant", {1'b0, grant}, 4'h4);
    chk("dom_sel", {2'b0, sel}, 4'h2);
    chk("dom_latched", {3'b0, out_domain}, 4'h1);
    in_domain = 3'b000;
    #1;
    chk("dom_flip_b1", {3'b0, out_domain}, 4'h1);
    step();
    in_last = 3'b100;
    #1;
    chk("dom_flip_b2", {3'b0, out_domain}, 4'h1);
    chk("dom_b2_outval", {3'b0, out_val}, 4'h1);
    step();
    in_val = 3'b000;
    #1;
    chk("dom_idle_grant", {1'b0, grant}, 4'h0);
    chk("dom_idle_hold", {3'b0, out_domain}, 4'h1);
    chk("dom_idle_sel", {2'b0, sel}, 4'h2);

    // 5: H packet from req1 followed by L packet from req0
    in_val = 3'b010; in_domain = 3'b010; in_last = 3'b010;
    step();
    chk("scr_h_grant", {1'b0, grant}, 4'h2);
    chk("scr_h_dom", {3'b0, out_domain}, 4'h1);
    step();
    in_val = 3'b001; in_domain = 3'b000; in_last = 3'b001;
    #1;
    chk("scr_bubble_grant", {1'b0, grant}, 4'h0);
    step();
`ifdef VC_ARB_DOMAIN_SCRUB_EN
    chk("scr_gap_grant", {1'b0, grant}, 4'h1);
    chk("scr_gap_dom", {3'b0, out_domain}, 4'h0);
    chk("scr_gap_outval", {3'b0, out_val}, 4'h0);
    chk("scr_gap_inrdy", {1'b0, in_rdy}, 4'h0);
    step();
`endif
    chk("scr_l_grant", {1'b0, grant}, 4'h1);
    chk("scr_l_dom", {3'b0, out_domain}, 4'h0);
    chk("scr_l_outval", {3'b0, out_val}, 4'h1);
    step();
    in_val = 3'b000;

    // 6: reset mid-packet; pointer is 2 beforehand so a stale pointer would pick req2
    in_val = 3'b010; in_last = 3'b010;
    step();
    chk("rmp_pre_grant", {1'b0, grant}, 4'h2);
    step();
    in_val = 3'b001; in_last = 3'b000;
    step();
    chk("rmp_grant", {1'b0, grant}, 4'h1);
    step();
    reset = 1'b1;
    #1;
    chk("rmp_rst_outval", {3'b0, out_val}, 4'h0);
    chk("rmp_rst_inrdy", {1'b0, in_rdy}, 4'h0);
    step();
    chk("rmp_after_grant", {1'b0, grant}, 4'h0);
    chk("rmp_after_sel", {2'b0, sel}, 4'h0);
    reset = 1'b0; in_val = 3'b110;
    #1;
    chk("rmp_idle_outval", {3'b0, out_val}, 4'h0);
    step();
    chk("rmp_regrant", {1'b0, grant}, 4'h2);
    chk("rmp_regrant_sel", {2'b0, sel}, 4'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
